// File: rtl/rtrt_pkg.sv
// Shared OCM port-A widths, default read latency and the grant-source encoding.
package rtrt_pkg;
    localparam int OCM_ADDR_W = 16;
    localparam int OCM_DATA_W = 16;
    localparam int OCM_RD_LAT = 3;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_RD,
        SRC_WR0,
        SRC_WR1
    } ocm_src_t;
endpackage

// File: rtl/ocm_port_a_arbiter_if.sv
// OCM port-A bundle: VGA read client, two ray-trace write clients and the RAM pins.
// master = requesters plus RAM model, slave = arbiter.
interface ocm_port_a_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        wr_gnt;
    logic [ADDR_W-1:0] ocm_addr;
    logic              ocm_we;
    logic [DATA_W-1:0] ocm_din;
    logic [DATA_W-1:0] ocm_dout;
    logic              rd_overrun;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, ocm_dout,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, ocm_addr, ocm_we, ocm_din, rd_overrun
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, ocm_dout,
        output rd_gnt, rd_valid, rd_data, wr_gnt, ocm_addr, ocm_we, ocm_din, rd_overrun
    );
endinterface

// File: rtl/ocm_port_a_arbiter_rr_arb2.sv
// Two-requester round-robin: combinational grant, rr_last advances only on acceptance.
// Latency 0; a loser keeps its request up and wins the next contested slot.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic rr_last;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (advance) begin
            rr_last <= gnt[1];
        end
    end
endmodule

// File: rtl/ocm_port_a_arbiter.sv
// OCM port-A arbiter: VGA reads first with a bounded run, writers round-robin; RD_LAT read return.
// Grants are combinational request/grant handshakes; nothing is buffered, requesters hold until granted.
module ocm_port_a_arbiter
    import rtrt_pkg::*;
#(
    parameter int ADDR_W     = OCM_ADDR_W,
    parameter int DATA_W     = OCM_DATA_W,
    parameter int RD_LAT     = OCM_RD_LAT,
    parameter int RD_RUN_MAX = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    ocm_port_a_arbiter_if.slave  bus
);
    localparam int RUN_W = (RD_RUN_MAX < 1) ? 1 : $clog2(RD_RUN_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RD_RUN_MAX);

    logic [RUN_W-1:0]  rd_run;
    logic              force_wr;
    logic              rd_gnt;
    logic [1:0]        arb_gnt;
    logic [1:0]        wr_gnt;
    logic              wr_acc;
    ocm_src_t          acc_src;
    ocm_src_t          issue_src;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              overrun_q;
    logic              rd_issued;
    logic              rd_last;

    assign wr_acc = |wr_gnt;

    rr_arb2 u_rr (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .req     (bus.wr_req),
        .advance (wr_acc),
        .gnt     (arb_gnt)
    );

    always_comb begin
        force_wr = (RD_RUN_MAX != 0) && (rd_run == RUN_MAX) && (|bus.wr_req);
        rd_gnt   = RESET_N && bus.rd_req && !force_wr;
        wr_gnt   = (RESET_N && !rd_gnt) ? arb_gnt : 2'b00;
        acc_src  = SRC_NONE;
        if (rd_gnt)         acc_src = SRC_RD;
        else if (wr_gnt[0]) acc_src = SRC_WR0;
        else if (wr_gnt[1]) acc_src = SRC_WR1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            issue_src  <= SRC_NONE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            din_q      <= '0;
            rd_run     <= '0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            issue_src <= acc_src;
            case (acc_src)
                SRC_RD: begin
                    addr_q <= bus.rd_addr;
                    we_q   <= 1'b0;
                    din_q  <= '0;
                end
                SRC_WR0: begin
                    addr_q <= bus.wr_addr0;
                    we_q   <= 1'b1;
                    din_q  <= bus.wr_data0;
                end
                SRC_WR1: begin
                    addr_q <= bus.wr_addr1;
                    we_q   <= 1'b1;
                    din_q  <= bus.wr_data1;
                end
                default: begin
                    we_q  <= 1'b0;
                    din_q <= '0;
                end
            endcase
            // Any non-read slot (write or idle) ends the read run.
            if (acc_src == SRC_RD) begin
                if (rd_run != RUN_MAX) rd_run <= rd_run + 1'b1;
            end else begin
                rd_run <= '0;
            end
            if (bus.rd_req && !rd_gnt) overrun_q <= 1'b1;
            rd_valid_q <= rd_last;
            if (rd_last) rd_data_q <= bus.ocm_dout;
        end
    end

    // The issue record is stage 0 of the read-valid pipe; the tail covers the RAM latency.
    assign rd_issued = (issue_src == SRC_RD);

    generate
        if (RD_LAT == 2) begin : g_short
            assign rd_last = rd_issued;
        end else begin : g_pipe
            logic [RD_LAT-3:0] vtail;
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) vtail <= '0;
                else          vtail <= (vtail << 1) | (RD_LAT-2)'(rd_issued);
            end
            assign rd_last = vtail[RD_LAT-3];
        end
    endgenerate

    assign bus.rd_gnt     = rd_gnt;
    assign bus.wr_gnt     = wr_gnt;
    assign bus.ocm_addr   = addr_q;
    assign bus.ocm_we     = we_q;
    assign bus.ocm_din    = din_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_overrun = overrun_q;
endmodule

// File: tb/tb_ocm_port_a_arbiter.sv
// Directed bench: one arbiter with a one-read run limit and one with pure read priority, same stimulus.
module tb_ocm_port_a_arbiter;
    logic CLK;
    logic RESET_N;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic seen;

    logic [15:0] mem [0:65535];

    ocm_port_a_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
    ocm_port_a_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();

    ocm_port_a_arbiter #(.RD_RUN_MAX(1)) u_dut1 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus1.slave)
    );

    ocm_port_a_arbiter #(.RD_RUN_MAX(0)) u_dut0 (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus0.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read RAM behind the run-limited arbiter.
    initial begin
        mem[16'h0123] = 16'hBEEF;
        bus1.ocm_dout = '0;
        forever begin
            @(posedge CLK);
            if (bus1.ocm_we) mem[bus1.ocm_addr] <= bus1.ocm_din;
            bus1.ocm_dout <= mem[bus1.ocm_addr];
        end
    end

    always @(posedge CLK) bus0.ocm_dout <= bus0.ocm_addr ^ 16'h5A5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rq, input logic [15:0] ra, input logic [1:0] wq);
        bus1.rd_req  = rq;
        bus0.rd_req  = rq;
        bus1.rd_addr = ra;
        bus0.rd_addr = ra;
        bus1.wr_req  = wq;
        bus0.wr_req  = wq;
    endtask

    logic [1:0]  rr_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] rr_addr [4] = '{16'h0A00, 16'h0B00, 16'h0A00, 16'h0B00};
    logic [15:0] rr_din  [4] = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
    logic        lim_rd  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        RESET_N = 1'b0;
        drive(1'b1, 16'h0123, 2'b11);
        bus1.wr_addr0 = 16'h0A00; bus0.wr_addr0 = 16'h0A00;
        bus1.wr_addr1 = 16'h0B00; bus0.wr_addr1 = 16'h0B00;
        bus1.wr_data0 = 16'h1111; bus0.wr_data0 = 16'h1111;
        bus1.wr_data1 = 16'h2222; bus0.wr_data1 = 16'h2222;
        repeat (3) tick();

        // Reset holds everything quiet even with every requester asking.
        check("rst_rd_gnt",   bus1.rd_gnt,     1'b0);
        check("rst_wr_gnt",   bus1.wr_gnt,     2'b00);
        check("rst_rd_gnt0",  bus0.rd_gnt,     1'b0);
        check("rst_ocm_addr", bus1.ocm_addr,   16'h0000);
        check("rst_ocm_we",   bus1.ocm_we,     1'b0);
        check("rst_ocm_din",  bus1.ocm_din,    16'h0000);
        check("rst_rd_valid", bus1.rd_valid,   1'b0);
        check("rst_rd_data",  bus1.rd_data,    16'h0000);
        check("rst_overrun",  bus1.rd_overrun, 1'b0);

        drive(1'b0, 16'h0123, 2'b11);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Round-robin, writer 0 first after reset.
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), bus1.wr_gnt, rr_gnt[i]);
            check($sformatf("rr_rdgnt%0d", i), bus1.rd_gnt, 1'b0);
            tick();
            check($sformatf("rr_addr%0d", i), bus1.ocm_addr, rr_addr[i]);
            check($sformatf("rr_din%0d", i),  bus1.ocm_din,  rr_din[i]);
            check($sformatf("rr_we%0d", i),   bus1.ocm_we,   1'b1);
        end

        drive(1'b0, 16'h0123, 2'b00);
        #1;
        check("idle_wr_gnt", bus1.wr_gnt, 2'b00);
        check("idle_rd_gnt", bus1.rd_gnt, 1'b0);
        tick();
        check("idle_we",   bus1.ocm_we,   1'b0);
        check("idle_din",  bus1.ocm_din,  16'h0000);
        check("idle_addr", bus1.ocm_addr, 16'h0B00);

        // Single read: valid on the third register stage after acceptance.
        drive(1'b1, 16'h0123, 2'b00);
        #1;
        check("rd_gnt", bus1.rd_gnt, 1'b1);
        check("rd_wr_gnt", bus1.wr_gnt, 2'b00);
        tick();
        drive(1'b0, 16'h0123, 2'b00);
        check("rd_issue_addr", bus1.ocm_addr, 16'h0123);
        check("rd_issue_we",   bus1.ocm_we,   1'b0);
        check("rd_valid_c1",   bus1.rd_valid, 1'b0);
        tick();
        check("rd_valid_c2",   bus1.rd_valid, 1'b0);
        check("rd_we_c2",      bus1.ocm_we,   1'b0);
        tick();
        check("rd_valid_c3",   bus1.rd_valid, 1'b1);
        check("rd_data_c3",    bus1.rd_data,  16'hBEEF);
        tick();
        check("rd_valid_c4",   bus1.rd_valid, 1'b0);

        // Back-to-back reads of the words written earlier return in order.
        drive(1'b1, 16'h0A00, 2'b00);
        tick();
        drive(1'b1, 16'h0B00, 2'b00);
        tick();
        drive(1'b0, 16'h0000, 2'b00);
        tick();
        check("b2b_valid0", bus1.rd_valid, 1'b1);
        check("b2b_data0",  bus1.rd_data,  16'h1111);
        tick();
        check("b2b_valid1", bus1.rd_valid, 1'b1);
        check("b2b_data1",  bus1.rd_data,  16'h2222);
        tick();
        check("b2b_valid2", bus1.rd_valid, 1'b0);

        // Read-run limit versus pure read priority under identical contention.
        check("lim_overrun_pre", bus1.rd_overrun, 1'b0);
        drive(1'b1, 16'h0123, 2'b01);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("lim_rd_gnt%0d", i),  bus1.rd_gnt, lim_rd[i]);
            check($sformatf("lim_wr_gnt%0d", i),  bus1.wr_gnt, lim_rd[i] ? 2'b00 : 2'b01);
            check($sformatf("pure_rd_gnt%0d", i), bus0.rd_gnt, 1'b1);
            check($sformatf("pure_wr_gnt%0d", i), bus0.wr_gnt, 2'b00);
            tick();
            check($sformatf("lim_we%0d", i), bus1.ocm_we, !lim_rd[i]);
            if (i == 1) check("lim_overrun_set", bus1.rd_overrun, 1'b1);
        end
        check("lim_overrun_end",  bus1.rd_overrun, 1'b1);
        check("pure_overrun_end", bus0.rd_overrun, 1'b0);
        drive(1'b0, 16'h0000, 2'b00);
        repeat (5) tick();

        // A read in flight when reset hits must never return.
        drive(1'b1, 16'h0123, 2'b00);
        #1;
        check("mid_rd_gnt", bus1.rd_gnt, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 2'b00);
        tick();
        RESET_N = 1'b0;
        #1;
        check("mid_valid_in_rst", bus1.rd_valid, 1'b0);
        tick();
        RESET_N = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus1.rd_valid) seen = 1'b1;
        end
        check("mid_valid_never", seen, 1'b0);
        check("mid_overrun_clr", bus1.rd_overrun, 1'b0);
        check("mid_we",          bus1.ocm_we,     1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
